// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with valid/ready handshakes on both sides.
`ifndef WORD
`define WORD 32
`endif

module muldiv_unit #(
   parameter int unsigned WIDTH = `WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;
   state_t state, state_nx;

   logic [2:0]         op_q;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic               neg_q, spec_q;
   logic [CW-1:0]      cnt;

   logic               accept, is_div, s1_signed, s2_signed, sgn1, sgn2;
   logic               div_zero, ovf, special, neg;
   logic [WIDTH-1:0]   abs1, abs2, spec_val;

   always_comb begin
      is_div    = op[2];
      s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      sgn1      = s1_signed & src1[WIDTH-1];
      sgn2      = s2_signed & src2[WIDTH-1];
      abs1      = sgn1 ? -src1 : src1;
      abs2      = sgn2 ? -src2 : src2;
      div_zero  = is_div && (src2 == '0);
      ovf       = ((op == 3'd4) || (op == 3'd6)) &&
                  (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
      special   = div_zero || ovf;
      spec_val  = '0;
      if (div_zero)
         spec_val = op[1] ? src1 : '1;
      else if (ovf)
         spec_val = op[1] ? '0 : src1;
      // remainder follows the dividend; quotient and MULH* products use both signs
      neg       = (is_div && op[1]) ? sgn1 : (sgn1 ^ sgn2);
      accept    = in_valid && in_ready && !flush;
   end

   // Multiply keeps the multiplier in the low half and shifts right; divide keeps
   // the partial remainder in the high half and the dividend/quotient in the low half.
   logic [WIDTH-1:0]   mcand_sel;
   logic [WIDTH:0]     add_sum, shifted, sub_diff;
   logic [2*WIDTH-1:0] mul_nx, div_nx, full;
   logic [WIDTH-1:0]   div_sel, fin_val;

   always_comb begin
      mcand_sel = prod[0] ? mcand : '0;
      add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand_sel};
      mul_nx    = {add_sum, prod[WIDTH-1:1]};
      shifted   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      sub_diff  = shifted - {1'b0, mcand};
      if (sub_diff[WIDTH])
         div_nx = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else
         div_nx = {sub_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      full      = neg_q ? -prod : prod;
      div_sel   = op_q[1] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      if (spec_q)
         fin_val = prod[WIDTH-1:0];
      else if (op_q[2])
         fin_val = neg_q ? -div_sel : div_sel;
      else if (op_q[1:0] == 2'd0)
         fin_val = full[WIDTH-1:0];
      else
         fin_val = full[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid) state_nx = special ? FINISH : CALC;
            CALC:    if (cnt == '0) state_nx = FINISH;
            FINISH:  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         mcand  <= '0;
         prod   <= '0;
         neg_q  <= 1'b0;
         spec_q <= 1'b0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q   <= op;
               neg_q  <= neg;
               spec_q <= special;
               cnt    <= CW'(WIDTH - 1);
               if (special) begin
                  prod  <= {{WIDTH{1'b0}}, spec_val};
                  mcand <= '0;
               end else if (is_div) begin
                  prod  <= {{WIDTH{1'b0}}, abs1};
                  mcand <= abs2;
               end else begin
                  prod  <= {{WIDTH{1'b0}}, abs2};
                  mcand <= abs1;
               end
            end
            CALC: begin
               prod <= op_q[2] ? div_nx : mul_nx;
               cnt  <= cnt - CW'(1);
            end
            FINISH: if (!flush) result <= fin_val;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand selector. It consumes the same selected operands (`src1`, `src2`) as the single-cycle ALU, but only for M-extension instructions. It computes the result over multiple cycles with a valid/ready handshake on both sides, so the core can stall while the unit is busy.

## Interface
- `WIDTH`, default `` `WORD `` (32): operand/result width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and op are presented this cycle.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `op` in 3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1` in WIDTH: rs1 operand (multiplicand/dividend).
- `src2` in WIDTH: rs2 operand (multiplier/divisor).
- `flush` in 1: synchronous abort of the in-flight operation.
- `out_valid` out 1: `result` is valid; held until consumed.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: computed value.
- `busy` out 1: high in CALC, FINISH and DONE.

## Operation
- **States:** IDLE, CALC, FINISH, DONE.
- **IDLE:**
  - Acceptance is `in_valid && in_ready && !flush`.
  - On acceptance, latch `op`.
  - Latch the absolute values of the operands per signedness: signed for MULH/DIV/REM, src1 only for MULHSU, none for MULHU/DIVU/REMU/MUL. MUL uses the low WIDTH bits, which are sign-agnostic.
  - Latch the result-negate flag.
  - Load iteration counter = WIDTH − 1.
- **Multiply (CALC):**
  - Radix-2 shift-add into a 2·WIDTH product register, one multiplier bit per cycle.
  - Exactly WIDTH cycles.
- **Divide (CALC):**
  - Restoring, one quotient bit per cycle, using a WIDTH+1-bit remainder and subtractor.
  - Exactly WIDTH cycles.
- **FINISH:**
  - Apply two's-complement negation if needed.
  - Quotient sign = sign(src1) XOR sign(src2).
  - Remainder sign = sign(src1).
  - MULH/MULHSU product sign = sign(src1) XOR sign(src2), or sign(src1) for MULHSU; negate the full 2·WIDTH product.
  - Select the low half (MUL) or high half (MULH*) of the product.
  - Register `result` and go to DONE.
- **Special cases**, detected at acceptance; these bypass CALC (IDLE → FINISH):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → src1.
  - Signed overflow (src1 = 0x80000000, src2 = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **DONE:**
  - `out_valid` = 1, `result` stable.
  - On `out_ready`, go to IDLE.
  - No back-to-back accept in the same cycle; `in_ready` rises the following cycle.
- **flush:**
  - In any state, the next state is IDLE.
  - `out_valid` deasserts next cycle; the result is discarded.
  - Flush wins over a simultaneous `in_valid` or `out_ready`.
- **Inputs outside IDLE:** `src1`/`src2`/`op` are ignored; the unit works only from latched copies, so upstream may change them freely.
- **Reset (`rst_n` low, any time including mid-operation):**
  - State IDLE.
  - `out_valid` = 0, `busy` = 0, `result` = 0.
  - Counters and datapath registers = 0.
  - `in_ready` = 1.

## Timing
- Acceptance happens at rising edge k.
- Normal operation:
  - CALC during cycles k+1 … k+WIDTH.
  - FINISH at k+WIDTH+1.
  - `out_valid` is high from cycle k+WIDTH+2, i.e. 34 cycles for WIDTH = 32.
- Special-case latency: FINISH at k+1; `out_valid` from k+2.
- Handshake rules:
  - `out_valid` holds, with `result` constant, until the cycle where `out_ready` = 1.
  - `in_ready` = 1 the cycle after consumption.
- `in_ready`, `busy` and `out_valid` are decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset deassertion: the first acceptance is possible on the first rising edge with `rst_n` high.

## Test plan
- **MUL/MULHU:** 0xFFFFFFFF × 0xFFFFFFFF → MUL 0x00000001, MULHU 0xFFFFFFFE. `out_valid` exactly 34 cycles after accept.
- **Signed ops:**
  - MULH −7 × 3 → 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIVU 100 / 7 → 14; REMU → 2.
- **Divide by zero:** DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000 / −1 → 0x80000000, REM → 0. All results reach `out_valid` 2 cycles after accept.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles after `out_valid`; `result` stays stable and `in_ready` = 0. Release; `in_ready` = 1 next cycle. Toggle `src1` during CALC; result is unaffected.
- **Flush:** assert flush at CALC cycle 10 → IDLE next cycle, no `out_valid`. Flush coincident with `in_valid` in IDLE → not accepted.
- **Reset:** drop `rst_n` asynchronously mid-CALC → outputs immediately `out_valid` = 0, `busy` = 0, `result` = 0, `in_ready` = 1. After release, a new DIVU 9/3 returns 3 in 34 cycles.
